fb_clear_sequencer: RTL and testbench
=====================================

// Module: fb_clear_sequencer
// PURPOSE
//   Downstream consumer of the power-on reset pulse. After rst releases, waits a
//   settle interval, then writes a clear colour to every framebuffer address over
//   a valid/ready write port and raises init_done. Gates the renderer until the
//   framebuffer is known-clean. Also re-clears on request after init.
// PARAMETERS
//   ADDR_W        17      framebuffer address width
//   DEPTH         76800   number of words cleared (320x240); 1..2**ADDR_W
//   DATA_W        12      pixel width (RGB444)
//   CLEAR_VALUE   12'h000 colour used for the post-reset clear
//   SETTLE_CYCLES 4       idle cycles after rst release before first write; >=1
// PORTS
//   clk          in   1       single clock; all logic on posedge
//   rst          in   1       synchronous, active-high reset
//   clear_req    in   1       one-cycle pulse: re-clear with clear_color (DONE only)
//   clear_color  in   DATA_W  colour sampled on the accepted clear_req cycle
//   wr_ready     in   1       framebuffer accepts write this cycle
//   wr_valid     out  1       write request
//   wr_addr      out  ADDR_W  write address
//   wr_data      out  DATA_W  write data
//   busy         out  1       high in SETTLE and CLEAR
//   init_done    out  1       high only in DONE
// BEHAVIOUR
//   - All outputs registered. While rst=1: state=SETTLE, settle count=0,
//     wr_addr=0, colour reg=CLEAR_VALUE, wr_valid=0, init_done=0, busy=1,
//     wr_data=CLEAR_VALUE.
//   - States: SETTLE -> CLEAR -> DONE; DONE -> CLEAR on clear_req.
//   - SETTLE: cycle 0 = first cycle rst sampled low. Count SETTLE_CYCLES cycles;
//     wr_valid first high in cycle SETTLE_CYCLES with wr_addr=0.
//   - CLEAR: wr_valid=1, wr_data=colour reg. Transfer = wr_valid&wr_ready.
//     On transfer wr_addr+1; no transfer -> addr/data/valid held stable.
//     Transfer at wr_addr==DEPTH-1 -> DONE: next cycle wr_valid=0, wr_addr=0,
//     busy=0, init_done=1. Exactly DEPTH transfers per clear, no wrap.
//   - DONE: clear_req=1 -> colour reg<=clear_color, state CLEAR; next cycle
//     init_done=0, busy=1, wr_valid=1, wr_addr=0. No settle on re-clear.
//   - clear_req ignored in SETTLE/CLEAR (not queued).
//   - rst=1 mid-SETTLE/CLEAR/DONE: abort; next cycle reset values; full settle
//     + clear with CLEAR_VALUE repeats after release.
//   - clear_req and rst same cycle: rst wins.
//   - wr_addr compare is against DEPTH-1 at ADDR_W bits; DEPTH=2**ADDR_W legal.
// TESTING (bench uses DEPTH=16, SETTLE_CYCLES=4, DATA_W=12)
//   1 rst high 3 cycles, wr_ready=1 -> wr_valid rises in cycle 4 after release,
//     addrs 0..15 one per cycle, all data 12'h000, init_done=1 cycle 20.
//   2 wr_ready random 50% -> addr/data stable while stalled, exactly 16
//     transfers, no duplicate/skipped address, init_done after 16th.
//   3 In DONE pulse clear_req, clear_color=12'hF0A -> 16 writes of 12'hF0A,
//     init_done low during, high after.
//   4 clear_req pulses during SETTLE and CLEAR -> ignored; exactly one clear.
//   5 rst asserted at wr_addr=7 -> wr_valid=0 next cycle; after release full
//     settle, restart at addr 0 with CLEAR_VALUE.
//   6 clear_req and rst same cycle in DONE -> reset behaviour, colour=12'h000.

Source files
------------

// File: rtl/fb_clear_sequencer.sv
// Post-reset framebuffer clear: settle, write a colour to every address over a
// valid/ready port, then hold init_done until a re-clear is requested.
module fb_clear_sequencer #(
   parameter int                ADDR_W        = 17,
   parameter int                DEPTH         = 76800,
   parameter int                DATA_W        = 12,
   parameter logic [DATA_W-1:0] CLEAR_VALUE   = '0,
   parameter int                SETTLE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_req,
   input  logic [DATA_W-1:0] clear_color,
   input  logic              wr_ready,
   output logic              wr_valid,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              init_done,
   output logic [1:0]        fsm_state
);

   // Write port: a word moves on every cycle where wr_valid && wr_ready; while
   // wr_valid is high and wr_ready is low, wr_addr and wr_data are held stable.

   typedef enum logic [1:0] {
      S_SETTLE = 2'd0,
      S_CLEAR  = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam int                CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);

   state_t              state, state_next;
   logic [CNT_W-1:0]    settle_cnt, cnt_next;
   logic [ADDR_W-1:0]   addr_next;
   logic [DATA_W-1:0]   color, color_next;

   assign fsm_state = state;

   always_comb begin
      state_next = state;
      cnt_next   = settle_cnt;
      addr_next  = wr_addr;
      color_next = color;
      case (state)
         S_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) state_next = S_CLEAR;
            else                           cnt_next   = settle_cnt + CNT_W'(1);
         end
         S_CLEAR: begin
            // Explicit return to 0 keeps DEPTH == 2**ADDR_W from relying on wrap.
            if (wr_valid && wr_ready) begin
               if (wr_addr == LAST_ADDR) begin
                  state_next = S_DONE;
                  addr_next  = '0;
               end else begin
                  addr_next = wr_addr + ADDR_W'(1);
               end
            end
         end
         S_DONE: begin
            if (clear_req) begin
               color_next = clear_color;
               addr_next  = '0;
               state_next = S_CLEAR;
            end
         end
         default: state_next = S_SETTLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_SETTLE;
         settle_cnt <= '0;
         wr_addr    <= '0;
         color      <= CLEAR_VALUE;
         wr_data    <= CLEAR_VALUE;
         wr_valid   <= 1'b0;
         busy       <= 1'b1;
         init_done  <= 1'b0;
      end else begin
         state      <= state_next;
         settle_cnt <= cnt_next;
         wr_addr    <= addr_next;
         color      <= color_next;
         wr_data    <= color_next;
         wr_valid   <= (state_next == S_CLEAR);
         busy       <= (state_next != S_DONE);
         init_done  <= (state_next == S_DONE);
      end
   end

endmodule

// File: tb/tb_fb_clear_sequencer.sv
// Randomized bench for fb_clear_sequencer: a write-count reference model plus a
// scoreboard of expected (address, colour) transfers.
module tb_fb_clear_sequencer;

   localparam int                ADDR_W        = 4;
   localparam int                DEPTH         = 16;
   localparam int                DATA_W        = 12;
   localparam logic [DATA_W-1:0] CLEAR_VALUE   = 12'h000;
   localparam int                SETTLE_CYCLES = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              clear_req;
   logic [DATA_W-1:0] clear_color;
   logic              wr_ready;
   logic              wr_valid;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              busy;
   logic              init_done;
   logic [1:0]        fsm_state;

   always #5 clk = ~clk;

   fb_clear_sequencer #(
      .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W),
      .CLEAR_VALUE(CLEAR_VALUE), .SETTLE_CYCLES(SETTLE_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .clear_req(clear_req), .clear_color(clear_color),
      .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy), .init_done(init_done), .fsm_state(fsm_state)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: phase 0 = settling, 1 = clearing, 2 = done.
   int                m_phase  = 0;
   int                m_idle   = 0;
   int                m_writes = 0;
   logic [DATA_W-1:0] m_color  = CLEAR_VALUE;
   logic [ADDR_W+DATA_W-1:0] exp_q[$];
   int xfers = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic start_clear(input logic [DATA_W-1:0] c);
      m_phase  = 1;
      m_writes = 0;
      m_color  = c;
      for (int i = 0; i < DEPTH; i++) exp_q.push_back({ADDR_W'(i), c});
   endtask

   task automatic model_edge(input bit r, input bit q, input logic [DATA_W-1:0] cc, input bit rdy);
      if (r) begin
         m_phase  = 0;
         m_idle   = 0;
         m_writes = 0;
         m_color  = CLEAR_VALUE;
         exp_q.delete();
      end else begin
         case (m_phase)
            0: begin
               m_idle++;
               if (m_idle == SETTLE_CYCLES) start_clear(m_color);
            end
            1: if (rdy) begin
               m_writes++;
               if (m_writes == DEPTH) begin
                  m_phase  = 2;
                  m_writes = 0;
               end
            end
            default: if (q) start_clear(cc);
         endcase
      end
   endtask

   // Called at a negedge: drive inputs, score any transfer, step one clock, compare.
   task automatic cycle(input bit r, input bit q, input logic [DATA_W-1:0] cc, input bit rdy);
      logic [ADDR_W+DATA_W-1:0] e;
      rst = r; clear_req = q; clear_color = cc; wr_ready = rdy;
      if (!r && wr_valid && rdy) begin
         xfers++;
         if (exp_q.size() == 0) check("xfer_unexpected", 1, 0);
         else begin
            e = exp_q.pop_front();
            check("xfer_addr", 32'(wr_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
            check("xfer_data", 32'(wr_data), 32'(e[DATA_W-1:0]));
         end
      end
      @(posedge clk);
      model_edge(r, q, cc, rdy);
      @(negedge clk);
      check("wr_valid",  32'(wr_valid),  32'(m_phase == 1));
      check("wr_addr",   32'(wr_addr),   32'(m_writes));
      check("busy",      32'(busy),      32'(m_phase != 2));
      check("init_done", 32'(init_done), 32'(m_phase == 2));
      if (m_phase != 2) check("wr_data", 32'(wr_data), 32'(m_color));
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) cycle(1, 0, '0, 1);
   endtask

   task automatic run_to_done(input bit rand_ready, input bit rand_req);
      int n = 0;
      while (m_phase != 2 && n < 1000) begin
         cycle(0, rand_req ? ($urandom_range(0, 3) == 0) : 1'b0, DATA_W'($urandom),
               rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
         n++;
      end
   endtask

   initial begin
      int first_v, done_c, n;
      rst = 1; clear_req = 0; clear_color = '0; wr_ready = 1;
      @(negedge clk);

      // 1: fixed timing with wr_ready held high
      do_reset(3);
      first_v = -1; done_c = -1; xfers = 0;
      for (int k = 0; k < 30; k++) begin
         cycle(0, 0, '0, 1);
         if (wr_valid && first_v < 0) first_v = k + 1;
         if (init_done && done_c < 0) done_c = k + 1;
      end
      check("first_valid_cycle", 32'(first_v), 4);
      check("init_done_cycle", 32'(done_c), 20);
      check("t1_xfers", 32'(xfers), DEPTH);

      // 2: random backpressure
      do_reset(2);
      xfers = 0;
      run_to_done(1, 0);
      check("t2_xfers", 32'(xfers), DEPTH);
      check("t2_queue_empty", 32'(exp_q.size()), 0);

      // 3: re-clear with a new colour
      xfers = 0;
      cycle(0, 1, 12'hF0A, 1);
      run_to_done(1, 0);
      check("t3_xfers", 32'(xfers), DEPTH);
      check("t3_init_done", 32'(init_done), 1);

      // 4: requests during settle and clear are dropped
      do_reset(1);
      xfers = 0;
      cycle(0, 1, 12'h123, 1);
      cycle(0, 1, 12'h456, 1);
      run_to_done(1, 1);
      for (int i = 0; i < 10; i++) cycle(0, 0, '0, 1);
      check("t4_xfers", 32'(xfers), DEPTH);
      check("t4_still_done", 32'(init_done), 1);

      // 5: reset mid-clear at address 7
      do_reset(1);
      n = 0;
      while (!(wr_valid && wr_addr == 7) && n < 40) begin
         cycle(0, 0, '0, 1);
         n++;
      end
      check("t5_reach_addr7", 32'(wr_valid && wr_addr == 7), 1);
      cycle(1, 0, '0, 1);
      check("t5_abort_valid", 32'(wr_valid), 0);
      xfers = 0;
      run_to_done(1, 0);
      check("t5_xfers", 32'(xfers), DEPTH);

      // 6: reset beats clear_req in DONE; recleared with CLEAR_VALUE
      cycle(1, 1, 12'hABC, 1);
      check("t6_valid_low", 32'(wr_valid), 0);
      xfers = 0;
      run_to_done(0, 0);
      check("t6_xfers", 32'(xfers), DEPTH);

      // Random soak: rare resets, frequent requests, random backpressure
      for (int i = 0; i < 1500; i++)
         cycle($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
               DATA_W'($urandom), 1'($urandom_range(0, 1)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
